// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//
// Serial-in / parallel-out receiver. It rebuilds N-bit words from an MSB-first
// serial stream and presents each word on a registered valid/ready port. A
// frame-sync strobe (qualified by sin_valid) marks the first bit of a frame.
// A sin_valid=0 cycle is a stall: all state holds until the next valid bit.
//
// Build option:
//   PARITY_EN  when defined, each frame carries N data bits followed by one
//              even-parity bit. parity_err is then registered together with
//              data_out. When undefined, frames are N bits long and
//              parity_err is tied to 0.
//
// Parameters:
//   N      data word width (N >= 2)
//   CNT_W  bit-counter width; 2**CNT_W must exceed the frame length
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   sin         serial data bit, MSB first
//   sin_valid   sin carries a valid bit this cycle
//   sync        with sin_valid: this bit starts a new frame
//   data_out    received word (first serial bit in data_out[N-1])
//   data_valid  data_out holds a word not yet accepted
//   data_ready  consumer accepts the word when data_valid && data_ready
//   overrun     one-cycle pulse: an unaccepted word was overwritten
//   parity_err  parity flag for the word currently in data_out
// -----------------------------------------------------------------------------
module sipo_deserializer #(
   parameter int N     = 4,
   parameter int CNT_W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sin,
   input  logic         sin_valid,
   input  logic         sync,
   output logic [N-1:0] data_out,
   output logic         data_valid,
   input  logic         data_ready,
   output logic         overrun,
   output logic         parity_err
);

`ifdef PARITY_EN
   localparam int FRAME = N + 1;
`else
   localparam int FRAME = N;
`endif

   // The shift register only holds the bits that precede the last bit of a
   // frame; the last bit is taken straight from sin on the completing edge.
   localparam int SH_W = FRAME - 1;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [SH_W-1:0]  shreg_reg, shreg_next;
   logic [N-1:0]     data_reg, data_next;
   logic             valid_reg, valid_next;
   logic             overrun_reg, overrun_next;
   logic [N-1:0]     word_asm;
   logic             complete;
`ifdef PARITY_EN
   logic             perr_reg, perr_next;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         shreg_reg   <= '0;
         data_reg    <= '0;
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
`ifdef PARITY_EN
         perr_reg    <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         shreg_reg   <= shreg_next;
         data_reg    <= data_next;
         valid_reg   <= valid_next;
         overrun_reg <= overrun_next;
`ifdef PARITY_EN
         perr_reg    <= perr_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      shreg_next   = shreg_reg;
      complete     = 1'b0;
      data_next    = data_reg;
      valid_next   = valid_reg;
      overrun_next = 1'b0;
`ifdef PARITY_EN
      // The parity bit is the last bit; the data word is already complete.
      word_asm     = shreg_reg;
      perr_next    = perr_reg;
`else
      word_asm     = {shreg_reg, sin};
`endif

      case (state_reg)
         IDLE: begin
            if (sin_valid && sync) begin
               shreg_next = SH_W'(sin);
               cnt_next   = CNT_ONE;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (sin_valid) begin
               if (sync) begin
                  // A sync mid-frame restarts; the partial word is dropped.
                  shreg_next = SH_W'(sin);
                  cnt_next   = CNT_ONE;
               end else if (cnt_reg == CNT_LAST) begin
                  complete   = 1'b1;
                  cnt_next   = '0;
                  state_next = IDLE;
               end else begin
                  shreg_next = SH_W'({shreg_reg, sin});
                  cnt_next   = cnt_reg + CNT_ONE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // A completion always wins: the new word loads even if the old one
      // is accepted on the same edge, so data_valid stays high.
      if (complete) begin
         data_next    = word_asm;
         valid_next   = 1'b1;
         overrun_next = valid_reg && !data_ready;
`ifdef PARITY_EN
         perr_next    = ^{shreg_reg, sin};
`endif
      end else if (valid_reg && data_ready) begin
         valid_next = 1'b0;
      end
   end

   assign data_out   = data_reg;
   assign data_valid = valid_reg;
   assign overrun    = overrun_reg;
`ifdef PARITY_EN
   assign parity_err = perr_reg;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// -----------------------------------------------------------------------------
// tb_sipo_deserializer
//
// Bench for sipo_deserializer with N=4. Directed vectors come from a table of
// {inputs, expected outputs}; multi-cycle corner cases are hand-written
// sequences; a randomized phase is checked against a frame-level reference
// model that collects bits into a queue and packs each finished frame.
// -----------------------------------------------------------------------------
module tb_sipo_deserializer;

   localparam int N     = 4;
   localparam int CNT_W = 3;
`ifdef PARITY_EN
   localparam int FRAME = N + 1;
`else
   localparam int FRAME = N;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         sin;
   logic         sin_valid;
   logic         sync;
   logic         data_ready;
   logic [N-1:0] data_out;
   logic         data_valid;
   logic         overrun;
   logic         parity_err;

   int checks = 0;
   int errors = 0;
   int ncycle = 0;

   sipo_deserializer #(.N(N), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .sin_valid  (sin_valid),
      .sync       (sync),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (frame level) ----------------
   bit           frame_q[$];
   bit [N-1:0]   m_data;
   bit           m_valid;
   bit           m_ovr;
   bit           m_perr;
   bit           m_done;

   task automatic model_step();
      bit [N-1:0] w;
      bit         p;
      w      = '0;
      p      = 1'b0;
      m_done = 1'b0;
      if (rst) begin
         frame_q.delete();
         m_data  = '0;
         m_valid = 1'b0;
         m_ovr   = 1'b0;
         m_perr  = 1'b0;
         return;
      end
      if (sin_valid) begin
         if (sync) begin
            frame_q.delete();
            frame_q.push_back(sin);
         end else if (frame_q.size() > 0) begin
            frame_q.push_back(sin);
            if (frame_q.size() == FRAME) begin
               for (int i = 0; i < FRAME; i++) begin
                  if (i < N) w = (w << 1) | N'(frame_q[i]);
                  p = p ^ frame_q[i];
               end
               m_done = 1'b1;
               frame_q.delete();
            end
         end
      end
      m_ovr = m_done && m_valid && !data_ready;
      if (m_done) begin
         m_data  = w;
         m_valid = 1'b1;
         m_perr  = (FRAME > N) ? p : 1'b0;
      end else if (m_valid && data_ready) begin
         m_valid = 1'b0;
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
   task automatic cycle(input bit r, input bit s, input bit v, input bit y, input bit d);
      rst        = r;
      sin        = s;
      sin_valid  = v;
      sync       = y;
      data_ready = d;
      @(posedge clk);
      model_step();
      ncycle++;
      #1;
   endtask

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, ncycle, act, exp);
      end
   endtask

   // Send 'len' bits MSB first, sync on the first one.
   task automatic send(input logic [7:0] bits, input int len, input bit rdy);
      for (int i = 0; i < len; i++)
         cycle(1'b0, bits[len-1-i], 1'b1, (i == 0), rdy);
   endtask

`ifndef PARITY_EN
   typedef struct {
      bit         r, s, v, y, d;
      bit [N-1:0] dout;
      bit         dv, ov;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input bit s, input bit v, input bit y, input bit d,
                      input bit [N-1:0] dout, input bit dv, input bit ov);
      vec_t e;
      e.r = r; e.s = s; e.v = v; e.y = y; e.d = d;
      e.dout = dout; e.dv = dv; e.ov = ov;
      tbl.push_back(e);
   endtask
`endif

   initial begin
      rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; data_ready = 1'b0;

`ifndef PARITY_EN
      //    rst sin v sync rdy  dout     dv ov
      // reset
      add(1, 0, 0, 0, 0, 4'b0000, 0, 0);
      add(1, 0, 0, 0, 0, 4'b0000, 0, 0);
      // 0110, contiguous, ready high: valid for exactly one cycle
      add(0, 0, 1, 1, 1, 4'b0000, 0, 0);
      add(0, 1, 1, 0, 1, 4'b0000, 0, 0);
      add(0, 1, 1, 0, 1, 4'b0000, 0, 0);
      add(0, 0, 1, 0, 1, 4'b0110, 1, 0);
      add(0, 0, 0, 0, 1, 4'b0110, 0, 0);
      // 0111 with a 2-cycle stall between bits 2 and 3
      add(0, 0, 1, 1, 1, 4'b0110, 0, 0);
      add(0, 1, 1, 0, 1, 4'b0110, 0, 0);
      add(0, 1, 0, 0, 1, 4'b0110, 0, 0);
      add(0, 0, 0, 0, 1, 4'b0110, 0, 0);
      add(0, 1, 1, 0, 1, 4'b0110, 0, 0);
      add(0, 1, 1, 0, 1, 4'b0111, 1, 0);
      add(0, 0, 0, 0, 1, 4'b0111, 0, 0);
      // ready low: 1010 then 0101 -> overwrite with one overrun pulse
      add(0, 1, 1, 1, 0, 4'b0111, 0, 0);
      add(0, 0, 1, 0, 0, 4'b0111, 0, 0);
      add(0, 1, 1, 0, 0, 4'b0111, 0, 0);
      add(0, 0, 1, 0, 0, 4'b1010, 1, 0);
      add(0, 0, 1, 1, 0, 4'b1010, 1, 0);
      add(0, 1, 1, 0, 0, 4'b1010, 1, 0);
      add(0, 0, 1, 0, 0, 4'b1010, 1, 0);
      add(0, 1, 1, 0, 0, 4'b0101, 1, 1);
      add(0, 0, 0, 0, 0, 4'b0101, 1, 0);
      add(0, 0, 0, 0, 1, 4'b0101, 0, 0);
      // back-to-back frames; second completes on the accepting edge
      add(0, 1, 1, 1, 1, 4'b0101, 0, 0);
      add(0, 1, 1, 0, 1, 4'b0101, 0, 0);
      add(0, 0, 1, 0, 1, 4'b0101, 0, 0);
      add(0, 0, 1, 0, 0, 4'b1100, 1, 0);
      add(0, 0, 1, 1, 0, 4'b1100, 1, 0);
      add(0, 0, 1, 0, 0, 4'b1100, 1, 0);
      add(0, 1, 1, 0, 0, 4'b1100, 1, 0);
      add(0, 1, 1, 0, 1, 4'b0011, 1, 0);
      add(0, 0, 0, 0, 1, 4'b0011, 0, 0);

      foreach (tbl[i]) begin
         cycle(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].y, tbl[i].d);
         check("tbl_dout", data_out, tbl[i].dout);
         check("tbl_valid", N'(data_valid), N'(tbl[i].dv));
         check("tbl_overrun", N'(overrun), N'(tbl[i].ov));
         check("tbl_perr", N'(parity_err), '0);
         $display("vec %0d: rst=%0d sin=%0d v=%0d sync=%0d rdy=%0d -> dout=%b dv=%0d ov=%0d",
                  i, tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].y, tbl[i].d,
                  data_out, data_valid, overrun);
      end

      // resync: sync+11 dropped by sync+1001
      send(8'b11, 2, 1'b1);
      check("resync_partial_valid", N'(data_valid), '0);
      send(8'b1001, 4, 1'b1);
      check("resync_dout", data_out, 4'b1001);
      check("resync_valid", N'(data_valid), N'(1));
      cycle(0, 0, 0, 0, 1);
      check("resync_accept", N'(data_valid), '0);
      $display("seq resync: word %b", 4'b1001);

      // reset after 2 bits, then unsynced bits: no word may appear
      send(8'b10, 2, 1'b0);
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
      check("midreset_valid", N'(data_valid), '0);
      check("midreset_dout", data_out, '0);
      $display("seq mid-frame reset: dv=%0d dout=%b", data_valid, data_out);
`else
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      check("reset_dout", data_out, '0);
      check("reset_perr", N'(parity_err), '0);
      send(8'b01100, 5, 1'b1);
      check("par_ok_dout", data_out, 4'b0110);
      check("par_ok_valid", N'(data_valid), N'(1));
      check("par_ok_perr", N'(parity_err), '0);
      send(8'b01101, 5, 1'b1);
      check("par_bad_dout", data_out, 4'b0110);
      check("par_bad_perr", N'(parity_err), N'(1));
      $display("seq parity: dout=%b perr=%0d", data_out, parity_err);
`endif

      // randomized phase against the reference model
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 149) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 5) == 0), 1'($urandom));
         check("rand_dout", data_out, m_data);
         check("rand_valid", N'(data_valid), N'(m_valid));
         check("rand_overrun", N'(overrun), N'(m_ovr));
         check("rand_perr", N'(parity_err), N'(m_perr));
         if (m_done)
            $display("rand word %b perr=%0d overrun=%0d at cycle %0d", m_data, m_perr, m_ovr, ncycle);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
